mem_port_arbiter: RTL

- Shares the core's single-port unified memory between NUM_REQ requesters, e.g. requester 0 = core fetch/load/store, requester 1 = program loader/DMA.
- Accepts at most one access per cycle and drives the memory port (we/address/data_out/data_in) combinationally from the granted requester.
- Routes read data back after the fixed memory read latency.
- Round-robin fairness with a bounded burst length per owner.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter_rr_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, index helper and response-pipeline entry for the memory port arbiter.
package mem_arb_pkg;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int NUM_REQ_MAX = 4;
    localparam int BURST_W     = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int IDX_W = clog2(NUM_REQ_MAX);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] id;
    } rsp_entry_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake plus the single memory port; slave = arbiter view, master = requester/memory view.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_we;
    logic [NUM_REQ*mem_arb_pkg::ADDR_W-1:0] req_addr;
    logic [NUM_REQ*mem_arb_pkg::DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]                     req_gnt;
    logic [NUM_REQ-1:0]                     rsp_valid;
    logic [mem_arb_pkg::DATA_W-1:0]         rsp_rdata;
    logic                                   we;
    logic [mem_arb_pkg::ADDR_W-1:0]         address;
    logic [mem_arb_pkg::DATA_W-1:0]         data_out;
    logic [mem_arb_pkg::DATA_W-1:0]         data_in;
    logic                                   busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, data_in,
        output req_gnt, rsp_valid, rsp_rdata, we, address, data_out, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, data_in,
        input  req_gnt, rsp_valid, rsp_rdata, we, address, data_out, busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Zero latency; no backpressure, it only looks at the request vector.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);
    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!vld_o && req_i[c]) begin
                vld_o    = 1'b1;
                idx_o    = IDX_W'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between NUM_REQ requesters: same-cycle grant, read data after MEM_LAT cycles.
// Requesters hold valid until granted; the current owner keeps the port for up to MAX_BURST grants while others wait.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    rsp_entry_t         pipe_q [MEM_LAT];
    rsp_entry_t         pipe_d [MEM_LAT];

    logic [NUM_REQ-1:0] pick_gnt, owner_oh, gnt_vec;
    logic [IDX_W-1:0]   pick_idx, gnt_idx;
    logic               pick_vld, others, retain, gnt_vld, gnt_we, busy_any;
    rsp_entry_t         head;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // Owner retention overrides the round-robin pick until its burst budget runs out.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
        others  = |(bus.req_valid & ~owner_oh);
        retain  = (|(bus.req_valid & owner_oh)) &&
                  ((burst_cnt_q < BURST_W'(MAX_BURST)) || !others);
        gnt_vld = !reset && (retain || pick_vld);
        gnt_idx = retain ? owner_q : pick_idx;
        gnt_vec = !gnt_vld ? '0 : (retain ? owner_oh : pick_gnt);
    end

    always_comb begin
        gnt_we       = 1'b0;
        bus.address  = '0;
        bus.data_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
                gnt_we       = bus.req_we[i];
                bus.address  = bus.req_addr[i*ADDR_W +: ADDR_W];
                bus.data_out = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_gnt   = gnt_vec;
    assign bus.we        = gnt_we;
    assign bus.rsp_rdata = bus.data_in;

    always_comb begin
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = '0;
        if (gnt_vld) begin
            if (gnt_idx == owner_q) begin
                burst_cnt_d = (burst_cnt_q >= BURST_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                                   : burst_cnt_q + 1'b1;
            end else begin
                owner_d     = gnt_idx;
                burst_cnt_d = BURST_W'(1);
            end
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        pipe_d[0].valid = gnt_vld && !gnt_we;
        pipe_d[0].id    = gnt_idx;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        head     = pipe_q[MEM_LAT-1];
        busy_any = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            busy_any = busy_any | pipe_q[i].valid;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = !reset && head.valid && (head.id == IDX_W'(i));
        end
        bus.busy = !reset && busy_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end
endmodule
